instr_fetch: RTL and testbench

- Front end of the core pipeline. Owns the program counter and drives the instruction ROM address.
- Captures the ROM's read data into the IF/ID register and hands {pc, instr} to decode over a valid/ready handshake.
- Handles branch/jump redirects, misaligned-target faults, halt, and a retired-fetch counter.
- The ROM reads on the falling edge, so the address held during cycle k-1 has its data stable at the rising edge of cycle k.

---
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, drives the ROM address, and presents
// {pc, instr} to decode through the IF/ID register with redirect, fault and halt control.
module instr_fetch #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] instr_addr,
  input  logic [31:0]      instr_in,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_instr,
  output logic             fetch_fault,
  output logic [WIDTH-1:0] fault_pc,
  output logic             halted,
  output logic [31:0]      fetch_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_BUBBLE = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_pc_q, out_pc_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [WIDTH-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]      fetch_count_q, fetch_count_d;

  // Handshake: a word moves to decode on any edge where out_valid && out_ready.
  // Decode may hold out_ready low indefinitely; the IF/ID register then holds steady.
  logic fire;
  logic stall;

  assign fire  = out_valid_q & out_ready;
  assign stall = out_valid_q & ~out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_BUBBLE;
      pc_q          <= RESET_VEC;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= NOP;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q & ~out_ready;  // a consumed word drops unless refilled
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q + 32'(fire);

    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      state_d     = S_FAULT;
      fault_pc_d  = redirect_pc;
      out_valid_d = 1'b0;
    end else if (redirect_valid) begin
      // The word the ROM is returning belongs to the old stream, so re-enter BUBBLE.
      state_d     = S_BUBBLE;
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      case (state_q)
        S_RUN: begin
          if (halt_req) begin
            state_d = S_HALTED;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = instr_in;
            pc_d        = pc_q + WIDTH'(4);
          end
        end
        S_HALTED: begin
          if (!halt_req) state_d = S_BUBBLE;
        end
        S_BUBBLE: state_d = S_RUN;
        default: ;
      endcase
    end
  end

  assign instr_addr  = pc_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_instr   = out_instr_q;
  assign fetch_fault = (state_q == S_FAULT);
  assign fault_pc    = fault_pc_q;
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table walks the main fetch, stall, redirect,
// fault, halt, wrap and reset scenarios; short hand sequences cover the remaining corners.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.WIDTH(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_addr    (instr_addr),
    .instr_in      (instr_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc),
    .halted        (halted),
    .fetch_count   (fetch_count),
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM model: word i = 0x1000_0000 + i, read on the falling edge
  initial instr_in = 32'h0;
  always @(negedge clk) instr_in = 32'h1000_0000 + (instr_addr >> 2);

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    logic        e_fault;
    logic [31:0] e_fpc;
    logic        e_halted;
    logic [31:0] e_count;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic h);
    rst_n          = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst, rdy, rv, rpc, halt | valid, out_pc, out_instr, addr, fault, fault_pc, halted, count
    vecs[0]  = '{0,1,0,32'h0,0,         0,32'h0,32'h13,32'h0,0,32'h0,0,0};
    vecs[1]  = '{1,1,0,32'h0,0,         0,32'h0,32'h13,32'h0,0,32'h0,0,0};
    vecs[2]  = '{1,1,0,32'h0,0,         1,32'h0,32'h1000_0000,32'h4,0,32'h0,0,0};
    vecs[3]  = '{1,1,0,32'h0,0,         1,32'h4,32'h1000_0001,32'h8,0,32'h0,0,1};
    vecs[4]  = '{1,1,0,32'h0,0,         1,32'h8,32'h1000_0002,32'hC,0,32'h0,0,2};
    vecs[5]  = '{1,0,0,32'h0,0,         1,32'h8,32'h1000_0002,32'hC,0,32'h0,0,2};
    vecs[6]  = '{1,0,0,32'h0,0,         1,32'h8,32'h1000_0002,32'hC,0,32'h0,0,2};
    vecs[7]  = '{1,0,0,32'h0,0,         1,32'h8,32'h1000_0002,32'hC,0,32'h0,0,2};
    vecs[8]  = '{1,1,0,32'h0,0,         1,32'hC,32'h1000_0003,32'h10,0,32'h0,0,3};
    vecs[9]  = '{1,1,0,32'h0,0,         1,32'h10,32'h1000_0004,32'h14,0,32'h0,0,4};
    vecs[10] = '{1,0,0,32'h0,0,         1,32'h10,32'h1000_0004,32'h14,0,32'h0,0,4};
    vecs[11] = '{1,0,1,32'h40,0,        0,32'h10,32'h1000_0004,32'h40,0,32'h0,0,4};
    vecs[12] = '{1,1,0,32'h0,0,         0,32'h10,32'h1000_0004,32'h40,0,32'h0,0,4};
    vecs[13] = '{1,1,0,32'h0,0,         1,32'h40,32'h1000_0010,32'h44,0,32'h0,0,4};
    vecs[14] = '{1,1,0,32'h0,0,         1,32'h44,32'h1000_0011,32'h48,0,32'h0,0,5};
    vecs[15] = '{1,1,1,32'h42,0,        0,32'h44,32'h1000_0011,32'h48,1,32'h42,0,6};
    vecs[16] = '{1,1,0,32'h0,0,         0,32'h44,32'h1000_0011,32'h48,1,32'h42,0,6};
    vecs[17] = '{1,1,0,32'h0,1,         0,32'h44,32'h1000_0011,32'h48,1,32'h42,0,6};
    vecs[18] = '{1,1,1,32'h80,0,        0,32'h44,32'h1000_0011,32'h80,0,32'h42,0,6};
    vecs[19] = '{1,1,0,32'h0,0,         0,32'h44,32'h1000_0011,32'h80,0,32'h42,0,6};
    vecs[20] = '{1,1,0,32'h0,0,         1,32'h80,32'h1000_0020,32'h84,0,32'h42,0,6};
    vecs[21] = '{1,1,0,32'h0,1,         0,32'h80,32'h1000_0020,32'h84,0,32'h42,1,7};
    vecs[22] = '{1,1,0,32'h0,1,         0,32'h80,32'h1000_0020,32'h84,0,32'h42,1,7};
    vecs[23] = '{1,1,0,32'h0,1,         0,32'h80,32'h1000_0020,32'h84,0,32'h42,1,7};
    vecs[24] = '{1,1,0,32'h0,1,         0,32'h80,32'h1000_0020,32'h84,0,32'h42,1,7};
    vecs[25] = '{1,1,0,32'h0,1,         0,32'h80,32'h1000_0020,32'h84,0,32'h42,1,7};
    vecs[26] = '{1,1,0,32'h0,0,         0,32'h80,32'h1000_0020,32'h84,0,32'h42,0,7};
    vecs[27] = '{1,1,0,32'h0,0,         0,32'h80,32'h1000_0020,32'h84,0,32'h42,0,7};
    vecs[28] = '{1,1,0,32'h0,0,         1,32'h84,32'h1000_0021,32'h88,0,32'h42,0,7};
    vecs[29] = '{1,1,0,32'h0,0,         1,32'h88,32'h1000_0022,32'h8C,0,32'h42,0,8};
    vecs[30] = '{1,1,1,32'hFFFF_FFFC,0, 0,32'h88,32'h1000_0022,32'hFFFF_FFFC,0,32'h42,0,9};
    vecs[31] = '{1,1,0,32'h0,0,         0,32'h88,32'h1000_0022,32'hFFFF_FFFC,0,32'h42,0,9};
    vecs[32] = '{1,1,0,32'h0,0,         1,32'hFFFF_FFFC,32'h4FFF_FFFF,32'h0,0,32'h42,0,9};
    vecs[33] = '{1,1,0,32'h0,0,         1,32'h0,32'h1000_0000,32'h4,0,32'h42,0,10};
    vecs[34] = '{0,1,0,32'h0,0,         0,32'h0,32'h13,32'h0,0,32'h0,0,0};
    vecs[35] = '{1,1,0,32'h0,0,         0,32'h0,32'h13,32'h0,0,32'h0,0,0};
    vecs[36] = '{1,1,0,32'h0,0,         1,32'h0,32'h1000_0000,32'h4,0,32'h0,0,0};

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].ready, vecs[i].rv, vecs[i].rpc, vecs[i].halt);
      check($sformatf("v%0d out_valid", i),   32'(out_valid),   32'(vecs[i].e_valid));
      check($sformatf("v%0d out_pc", i),      out_pc,           vecs[i].e_pc);
      check($sformatf("v%0d out_instr", i),   out_instr,        vecs[i].e_instr);
      check($sformatf("v%0d instr_addr", i),  instr_addr,       vecs[i].e_addr);
      check($sformatf("v%0d fetch_fault", i), 32'(fetch_fault), 32'(vecs[i].e_fault));
      check($sformatf("v%0d fault_pc", i),    fault_pc,         vecs[i].e_fpc);
      check($sformatf("v%0d halted", i),      32'(halted),      32'(vecs[i].e_halted));
      check($sformatf("v%0d fetch_count", i), fetch_count,      vecs[i].e_count);
    end

    // Redirect wins over a pending halt; the word consumed on that edge still counts
    drive(1, 1, 1, 32'h100, 1);
    check("h1 instr_addr", instr_addr, 32'h100);
    check("h1 out_valid", 32'(out_valid), 32'h0);
    check("h1 halted", 32'(halted), 32'h0);
    check("h1 fetch_count", fetch_count, 32'h1);
    drive(1, 1, 0, 32'h0, 1);
    check("h2 halted", 32'(halted), 32'h0);
    check("h2 instr_addr", instr_addr, 32'h100);
    drive(1, 1, 0, 32'h0, 1);
    check("h3 halted", 32'(halted), 32'h1);
    check("h3 dbg_state", 32'(dbg_state), 32'h2);
    check("h3 out_valid", 32'(out_valid), 32'h0);
    check("h3 instr_addr", instr_addr, 32'h100);

    // Misaligned redirect out of HALTED, then reset while faulted
    drive(1, 1, 1, 32'h3, 0);
    check("h4 fetch_fault", 32'(fetch_fault), 32'h1);
    check("h4 fault_pc", fault_pc, 32'h3);
    check("h4 halted", 32'(halted), 32'h0);
    check("h4 instr_addr", instr_addr, 32'h100);
    drive(0, 1, 0, 32'h0, 0);
    check("h5 fetch_fault", 32'(fetch_fault), 32'h0);
    check("h5 fault_pc", fault_pc, 32'h0);
    check("h5 instr_addr", instr_addr, 32'h0);
    check("h5 fetch_count", fetch_count, 32'h0);

    // Reset while stalled
    drive(1, 0, 0, 32'h0, 0);
    check("h6 out_valid", 32'(out_valid), 32'h0);
    drive(1, 0, 0, 32'h0, 0);
    check("h7 out_valid", 32'(out_valid), 32'h1);
    check("h7 out_instr", out_instr, 32'h1000_0000);
    drive(1, 0, 0, 32'h0, 0);
    check("h8 out_valid", 32'(out_valid), 32'h1);
    check("h8 instr_addr", instr_addr, 32'h4);
    drive(0, 0, 0, 32'h0, 0);
    check("h9 out_valid", 32'(out_valid), 32'h0);
    check("h9 out_instr", out_instr, 32'h13);
    check("h9 out_pc", out_pc, 32'h0);
    check("h9 instr_addr", instr_addr, 32'h0);
    check("h9 fetch_count", fetch_count, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
